// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: CP0 register set, timer, interrupt request and exception/ERET
// control for the openmips core. Sits beside MEM and redirects the front end.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i       MTC0 write port (WB stage)
//   raddr_i, rdata_o             MFC0 read port (EX stage), combinational
//   int_i                        level-sensitive hardware interrupt lines
//   exc_valid_i, exc_code_i,
//   exc_pc_i, exc_in_delayslot_i exception event from MEM
//   eret_i                       ERET event from MEM
//   int_req_o                    interrupt pending and enabled
//   timer_int_o                  sticky Count==Compare flag
//   flush_o, new_pc_o            one-cycle flush pulse and its redirect PC
//   status_o, cause_o, epc_o     current register values
module cp0_exc_unit #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] PRID       = 32'h004C_0102
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [DATA_W-1:0]     rdata_o,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [DATA_W-1:0]     exc_pc_i,
  input  logic                  exc_in_delayslot_i,
  input  logic                  eret_i,
  output logic                  int_req_o,
  output logic                  timer_int_o,
  output logic                  flush_o,
  output logic [DATA_W-1:0]     new_pc_o,
  output logic [DATA_W-1:0]     status_o,
  output logic [DATA_W-1:0]     cause_o,
  output logic [DATA_W-1:0]     epc_o
);

  localparam logic [4:0]  A_COUNT   = 5'd9;
  localparam logic [4:0]  A_COMPARE = 5'd11;
  localparam logic [4:0]  A_STATUS  = 5'd12;
  localparam logic [4:0]  A_CAUSE   = 5'd13;
  localparam logic [4:0]  A_EPC     = 5'd14;
  localparam logic [4:0]  A_PRID    = 5'd15;
  localparam logic [4:0]  A_CONFIG  = 5'd16;
  localparam logic [31:0] CONFIG_VAL  = 32'h0000_8000;
  localparam logic [31:0] STATUS_RST  = 32'h1000_0000;
  // CU0, IM[7:0], EXL, IE
  localparam logic [31:0] STATUS_MASK = 32'h1000_FF03;

  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [31:0]           r_status;
  logic                  r_cause_bd;
  logic [4:0]            r_cause_exc;
  logic [1:0]            r_cause_ip_sw;
  logic [NUM_HW_INT-1:0] r_cause_ip_hw;
  logic [31:0]           r_epc;
  logic                  r_timer_int;
  logic                  r_flush;
  logic [31:0]           r_new_pc;

  logic [31:0] w_cause;
  logic [31:0] w_rdata;
  logic [31:0] w_exc_epc;
  logic        w_wr_count;
  logic        w_wr_compare;

  always_comb begin
    w_cause       = '0;
    w_cause[31]   = r_cause_bd;
    w_cause[9:8]  = r_cause_ip_sw;
    w_cause[6:2]  = r_cause_exc;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      w_cause[10+i] = r_cause_ip_hw[i];
    end
  end

  // A delay-slot fault restarts at the branch, one word earlier.
  assign w_exc_epc    = exc_in_delayslot_i ? (exc_pc_i[31:0] - 32'd4) : exc_pc_i[31:0];
  assign w_wr_count   = we_i && (waddr_i == A_COUNT);
  assign w_wr_compare = we_i && (waddr_i == A_COMPARE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_compare     <= '0;
      r_status      <= STATUS_RST;
      r_cause_bd    <= 1'b0;
      r_cause_exc   <= '0;
      r_cause_ip_sw <= '0;
      r_cause_ip_hw <= '0;
      r_epc         <= '0;
      r_timer_int   <= 1'b0;
      r_flush       <= 1'b0;
      r_new_pc      <= '0;
    end else begin
      r_count       <= w_wr_count ? wdata_i[31:0] : r_count + 32'd1;
      r_cause_ip_hw <= int_i;
      r_flush       <= 1'b0;

      if (w_wr_compare) begin
        r_compare <= wdata_i[31:0];
      end

      // Writing Compare acknowledges the timer, even against a fresh match.
      if (w_wr_compare) begin
        r_timer_int <= 1'b0;
      end else if ((r_compare != 32'd0) && (r_count == r_compare)) begin
        r_timer_int <= 1'b1;
      end

      if (exc_valid_i) begin
        // Nested exceptions keep the original return point.
        if (!r_status[1]) begin
          r_epc      <= w_exc_epc;
          r_cause_bd <= exc_in_delayslot_i;
        end
        r_status[1] <= 1'b1;
        r_cause_exc <= exc_code_i;
        r_flush     <= 1'b1;
        r_new_pc    <= EXC_VECTOR;
      end else if (eret_i) begin
        r_status[1] <= 1'b0;
        r_flush     <= 1'b1;
        r_new_pc    <= r_epc;
      end else if (we_i) begin
        case (waddr_i)
          A_STATUS: r_status      <= wdata_i[31:0] & STATUS_MASK;
          A_CAUSE:  r_cause_ip_sw <= wdata_i[9:8];
          A_EPC:    r_epc         <= wdata_i[31:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    case (raddr_i)
      A_COUNT:   w_rdata = r_count;
      A_COMPARE: w_rdata = r_compare;
      A_STATUS:  w_rdata = r_status;
      A_CAUSE:   w_rdata = w_cause;
      A_EPC:     w_rdata = r_epc;
      A_PRID:    w_rdata = PRID;
      A_CONFIG:  w_rdata = CONFIG_VAL;
      default:   w_rdata = '0;
    endcase
  end

  assign rdata_o     = DATA_W'(w_rdata);
  assign int_req_o   = r_status[0] & ~r_status[1] & (|(w_cause[15:8] & r_status[15:8]));
  assign timer_int_o = r_timer_int;
  assign flush_o     = r_flush;
  assign new_pc_o    = DATA_W'(r_new_pc);
  assign status_o    = DATA_W'(r_status);
  assign cause_o     = DATA_W'(w_cause);
  assign epc_o       = DATA_W'(r_epc);

endmodule
